// File: rtl/tlul_sram_slave_if.sv
// TL-UL A/D channel bundle between a requester and tlul_sram_slave.
// The master modport drives requests and d_ready; the slave modport returns responses.
interface tlul_sram_slave_if #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned SIZE_WIDTH   = 3,
  parameter int unsigned SRC_WIDTH    = 2,
  parameter int unsigned SINK_WIDTH   = 1,
  parameter int unsigned OPCODE_WIDTH = 3,
  parameter int unsigned PARAM_WIDTH  = 3
);
  localparam int unsigned MaskWidth = DATA_WIDTH / 8;

  logic                    a_valid;
  logic                    a_ready;
  logic [OPCODE_WIDTH-1:0] a_opcode;
  logic [PARAM_WIDTH-1:0]  a_param;
  logic [SIZE_WIDTH-1:0]   a_size;
  logic [SRC_WIDTH-1:0]    a_source;
  logic [ADDR_WIDTH-1:0]   a_address;
  logic [MaskWidth-1:0]    a_mask;
  logic [DATA_WIDTH-1:0]   a_data;

  logic                    d_valid;
  logic                    d_ready;
  logic [OPCODE_WIDTH-1:0] d_opcode;
  logic [PARAM_WIDTH-1:0]  d_param;
  logic [SIZE_WIDTH-1:0]   d_size;
  logic [SRC_WIDTH-1:0]    d_source;
  logic [SINK_WIDTH-1:0]   d_sink;
  logic [DATA_WIDTH-1:0]   d_data;
  logic                    d_error;

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
    input  a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error
  );

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
    output a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error
  );
endinterface

// File: rtl/tlul_sram_slave.sv
// TL-UL slave: Get/PutFullData/PutPartialData on a local word SRAM, responses via a small FIFO.
// Define TLUL_SLAVE_STATS_EN to add saturating request/error counters (stat_req_cnt, stat_err_cnt).
module tlul_sram_slave #(
  parameter int unsigned           ADDR_WIDTH   = 32,
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter int unsigned           SIZE_WIDTH   = 3,
  parameter int unsigned           SRC_WIDTH    = 2,
  parameter int unsigned           SINK_WIDTH   = 1,
  parameter int unsigned           OPCODE_WIDTH = 3,
  parameter int unsigned           PARAM_WIDTH  = 3,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
  parameter int unsigned           MEM_WORDS    = 1024,
  parameter int unsigned           RSP_DEPTH    = 2
) (
  input logic              clk_100,
  input logic              reset,
  tlul_sram_slave_if.slave tl
`ifdef TLUL_SLAVE_STATS_EN
  ,
  output logic [15:0]      stat_req_cnt,
  output logic [15:0]      stat_err_cnt
`endif
);
  localparam int unsigned MaskWidth = DATA_WIDTH / 8;
  localparam int unsigned LgMask    = $clog2(MaskWidth);
  localparam int unsigned IdxW      = $clog2(MEM_WORDS);
  localparam int unsigned PtrW      = $clog2(RSP_DEPTH);
  localparam int unsigned CntW      = PtrW + 1;
  localparam logic [ADDR_WIDTH:0]   MemBytes = (ADDR_WIDTH + 1)'(MEM_WORDS * MaskWidth);
  localparam logic [OPCODE_WIDTH-1:0] OpPutFull = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OpPutPart = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OpGet     = OPCODE_WIDTH'(4);

  logic [DATA_WIDTH-1:0]   r_mem [MEM_WORDS];

  logic [OPCODE_WIDTH-1:0] r_fop   [RSP_DEPTH];
  logic [SIZE_WIDTH-1:0]   r_fsize [RSP_DEPTH];
  logic [SRC_WIDTH-1:0]    r_fsrc  [RSP_DEPTH];
  logic [DATA_WIDTH-1:0]   r_fdata [RSP_DEPTH];
  logic                    r_ferr  [RSP_DEPTH];
  logic [PtrW-1:0]         r_wptr, r_rptr;
  logic [CntW-1:0]         r_count;

  logic                    w_full, w_a_fire, w_d_fire, w_is_get, w_d_valid;
  logic                    w_range_bad, w_size_bad, w_op_bad, w_mask_bad, w_misalign, w_err;
  logic [ADDR_WIDTH-1:0]   w_off;
  logic [LgMask-1:0]       w_lo;
  logic [MaskWidth-1:0]    w_lanes;
  logic [IdxW-1:0]         w_idx;
  logic [DATA_WIDTH-1:0]   w_rdata;
  logic                    w_unused;

  assign w_unused = ^tl.a_param;

  assign w_full    = (r_count == CntW'(RSP_DEPTH));
  assign w_a_fire  = tl.a_valid && !w_full && reset;
  assign w_d_valid = (r_count != '0);
  assign w_d_fire  = w_d_valid && tl.d_ready;
  assign w_is_get  = (tl.a_opcode == OpGet);

  assign w_off   = tl.a_address - BASE_ADDR;
  assign w_lo    = tl.a_address[LgMask-1:0];
  assign w_idx   = w_off[LgMask +: IdxW];
  assign w_rdata = r_mem[w_idx];

  // Covered lanes are those sharing the addressed 2^size-byte block within the word.
  always_comb begin
    w_lanes    = '0;
    w_misalign = 1'b0;
    for (int unsigned b = 0; b < LgMask; b++) begin
      if (b < 32'(tl.a_size) && w_lo[b]) w_misalign = 1'b1;
    end
    for (int unsigned i = 0; i < MaskWidth; i++) begin
      if ((i >> tl.a_size) == (32'(w_lo) >> tl.a_size)) w_lanes[i] = 1'b1;
    end
  end

  assign w_range_bad = (tl.a_address < BASE_ADDR) || ({1'b0, w_off} >= MemBytes);
  assign w_size_bad  = (tl.a_size > SIZE_WIDTH'(LgMask));
  assign w_op_bad    = !(tl.a_opcode == OpPutFull || tl.a_opcode == OpPutPart || w_is_get);
  assign w_mask_bad  = (|(tl.a_mask & ~w_lanes)) ||
                       ((tl.a_opcode == OpPutFull) && (tl.a_mask != w_lanes));
  assign w_err       = w_range_bad || w_size_bad || w_op_bad || w_mask_bad || w_misalign;

  always_ff @(posedge clk_100) begin
    if (w_a_fire && !w_err && !w_is_get) begin
      for (int unsigned i = 0; i < MaskWidth; i++) begin
        if (tl.a_mask[i]) r_mem[w_idx][8*i +: 8] <= tl.a_data[8*i +: 8];
      end
    end
  end

  // Read data is captured at acceptance so later writes cannot change a queued response.
  always_ff @(posedge clk_100) begin
    if (w_a_fire) begin
      r_fop[r_wptr]   <= w_is_get ? OPCODE_WIDTH'(1) : OPCODE_WIDTH'(0);
      r_fsize[r_wptr] <= tl.a_size;
      r_fsrc[r_wptr]  <= tl.a_source;
      r_fdata[r_wptr] <= (w_is_get && !w_err) ? w_rdata : '0;
      r_ferr[r_wptr]  <= w_err;
    end
  end

  always_ff @(posedge clk_100) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_a_fire) r_wptr <= r_wptr + PtrW'(1);
      if (w_d_fire) r_rptr <= r_rptr + PtrW'(1);
      if (w_a_fire && !w_d_fire)      r_count <= r_count + CntW'(1);
      else if (!w_a_fire && w_d_fire) r_count <= r_count - CntW'(1);
    end
  end

  assign tl.a_ready  = !w_full;
  assign tl.d_valid  = w_d_valid;
  assign tl.d_opcode = w_d_valid ? r_fop[r_rptr]   : '0;
  assign tl.d_size   = w_d_valid ? r_fsize[r_rptr] : '0;
  assign tl.d_source = w_d_valid ? r_fsrc[r_rptr]  : '0;
  assign tl.d_data   = w_d_valid ? r_fdata[r_rptr] : '0;
  assign tl.d_error  = w_d_valid ? r_ferr[r_rptr]  : 1'b0;
  assign tl.d_param  = '0;
  assign tl.d_sink   = '0;

`ifdef TLUL_SLAVE_STATS_EN
  logic [15:0] r_req_cnt, r_err_cnt;

  always_ff @(posedge clk_100) begin
    if (!reset) begin
      r_req_cnt <= '0;
      r_err_cnt <= '0;
    end else if (w_a_fire) begin
      if (r_req_cnt != 16'hFFFF)          r_req_cnt <= r_req_cnt + 16'd1;
      if (w_err && r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign stat_req_cnt = r_req_cnt;
  assign stat_err_cnt = r_err_cnt;
`endif
endmodule
